// File: rtl/video_pkg.sv
// Shared video constants and the line-sequencer state encoding,
// also used by the timing generator.
package video_pkg;
   localparam int V_ACTIVE = 480;
   localparam int LINE_W   = 10;

   typedef enum logic [2:0] {IDLE, L0, L1, SPR, DONE} seq_state_t;
endpackage

// File: rtl/video_line_sequencer.sv
// Per-scanline render scheduler: picks the next line on each boundary, flips the
// line buffer, and runs layer0 -> layer1 -> sprites over the shared VRAM port.
module video_line_sequencer
   import video_pkg::*;
#(
   parameter int V_ACTIVE_P = V_ACTIVE,
   parameter int LINE_W_P   = LINE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                next_frame,
   input  logic                next_line,
   input  logic                layer0_en,
   input  logic                layer1_en,
   input  logic                sprites_en,
   input  logic                l0_done,
   input  logic                l1_done,
   input  logic                spr_done,
   output logic                l0_start,
   output logic                l1_start,
   output logic                spr_start,
   output logic                render_abort,
   output logic [LINE_W_P-1:0] render_line,
   output logic                linebuf_sel,
   output logic                busy,
   output logic                overrun,
   output logic                overrun_sticky
);

   seq_state_t          state, tgt, boundary_stage;
   logic [2:0]          en_q;
   logic [LINE_W_P-1:0] line_nxt;
   logic                done_acc, launch;

   // First enabled stage strictly after cur; en = {layer0, layer1, sprites}.
   function automatic seq_state_t next_stage(input logic [2:0] en, input seq_state_t cur);
      seq_state_t r;
      r = DONE;
      case (cur)
         L0:      r = en[1] ? L1 : (en[0] ? SPR : DONE);
         L1:      r = en[0] ? SPR : DONE;
         SPR:     r = DONE;
         default: r = en[2] ? L0 : (en[1] ? L1 : (en[0] ? SPR : DONE));
      endcase
      return r;
   endfunction

   assign busy = (state == L0) || (state == L1) || (state == SPR);

   always_comb begin
      line_nxt = next_frame ? '0 : ((&render_line) ? render_line : render_line + 1'b1);
      boundary_stage = (int'(line_nxt) < V_ACTIVE_P)
                     ? next_stage({layer0_en, layer1_en, sprites_en}, IDLE) : DONE;
      // A done in the cycle its start is pulsed belongs to the previous request.
      case (state)
         L0:      done_acc = l0_done  && !l0_start;
         L1:      done_acc = l1_done  && !l1_start;
         SPR:     done_acc = spr_done && !spr_start;
         default: done_acc = 1'b0;
      endcase
      launch = next_line || done_acc;
      if (next_line)     tgt = boundary_stage;
      else if (done_acc) tgt = next_stage(en_q, state);
      else               tgt = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         en_q           <= '0;
         render_line    <= LINE_W_P'(V_ACTIVE_P);
         linebuf_sel    <= 1'b0;
         l0_start       <= 1'b0;
         l1_start       <= 1'b0;
         spr_start      <= 1'b0;
         render_abort   <= 1'b0;
         overrun        <= 1'b0;
         overrun_sticky <= 1'b0;
      end else begin
         state        <= tgt;
         l0_start     <= launch && (tgt == L0);
         l1_start     <= launch && (tgt == L1);
         spr_start    <= launch && (tgt == SPR);
         render_abort <= next_line && busy;
         overrun      <= next_line && busy;
         if (next_line) begin
            render_line <= line_nxt;
            linebuf_sel <= ~linebuf_sel;
            en_q        <= {layer0_en, layer1_en, sprites_en};
            // An overrun on the frame boundary itself stays visible.
            if (busy)            overrun_sticky <= 1'b1;
            else if (next_frame) overrun_sticky <= 1'b0;
         end
      end
   end

endmodule
